// File: rtl/chip8_sprite_draw_ctrl_if.sv
// Port bundle for chip8_sprite_draw_ctrl: CPU request/status, sprite memory
// read port and framebuffer byte read/write ports.
// slave = the draw controller, master = the surrounding system.
interface chip8_sprite_draw_ctrl_if #(
  parameter int ADDR_W = 12
);
  // CPU request / status
  logic              start;
  logic              op;
  logic [7:0]        vx;
  logic [7:0]        vy;
  logic [3:0]        n;
  logic [ADDR_W-1:0] i_addr;
  logic              busy;
  logic              done;
  logic              collision;
  // sprite memory
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_readdata;
  // framebuffer
  logic [7:0]        fbvx_read;
  logic [7:0]        fbvy_read;
  logic [7:0]        fb_readdata;
  logic [7:0]        fbvx_write;
  logic [7:0]        fbvy_write;
  logic [7:0]        fbdata;
  logic              fb_write;

  modport slave (
    input  start, op, vx, vy, n, i_addr, mem_readdata, fb_readdata,
    output busy, done, collision, mem_addr, fbvx_read, fbvy_read,
           fbvx_write, fbvy_write, fbdata, fb_write
  );

  modport master (
    output start, op, vx, vy, n, i_addr, mem_readdata, fb_readdata,
    input  busy, done, collision, mem_addr, fbvx_read, fbvy_read,
           fbvx_write, fbvy_write, fbdata, fb_write
  );
endinterface

// File: rtl/chip8_sprite_draw_ctrl.sv
// CHIP-8 sprite draw (DXYN) / clear screen (00E0) sequencer.
// Fetches sprite rows, XOR-merges them into the framebuffer byte by byte and
// accumulates the VF collision flag.
// Optional feature macro: CHIP8_SPRITE_WRAP_EN (wrap sprites around the screen
// edges instead of clipping them).
module chip8_sprite_draw_ctrl #(
  parameter int FB_W   = 64,
  parameter int FB_H   = 32,
  parameter int ADDR_W = 12
) (
  input  logic                    clk,
  input  logic                    reset_n,
  chip8_sprite_draw_ctrl_if.slave bus
);
  localparam logic [7:0] XLAST = 8'(FB_W - 8);
  localparam logic [7:0] YLAST = 8'(FB_H - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, FETCH, MERGE, WRAP_RD, WRAP_WR, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        n_q, n_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0]        r_q, r_d;
  logic [7:0]        y_q, y_d;
  logic [7:0]        xa_q, xa_d;
  logic [2:0]        sh_q, sh_d;
  logic [7:0]        clr_x_q, clr_x_d;
  logic              collision_q, collision_d;

  logic [7:0] x0, y0, s, ext_lo, y_step;
  logic       row_last, row_done;

  // Origin folded onto the screen at start time.
  assign x0 = 8'({1'b0, bus.vx} % 9'(FB_W));
  assign y0 = 8'({1'b0, bus.vy} % 9'(FB_H));

  // Bit-reverse the sprite byte so pixel x+i sits at bit i.
  for (genvar gi = 0; gi < 8; gi++) begin : g_rev
    assign s[gi] = bus.mem_readdata[7-gi];
  end

  assign y_step = (y_q == YLAST) ? 8'd0 : y_q + 8'd1;

`ifdef CHIP8_SPRITE_WRAP_EN
  logic [7:0]  ovf_q, ovf_d;
  logic [15:0] ext_w;
  logic [7:0]  ext_hi;
  assign ext_w    = {8'h00, s} << sh_q;
  assign ext_lo   = ext_w[7:0];
  assign ext_hi   = ext_w[15:8];
  assign row_last = (r_q == n_q - 4'd1);
`else
  // Pixels past the right edge are simply shifted out.
  assign ext_lo   = s << sh_q;
  assign row_last = (r_q == n_q - 4'd1) || (y_q == YLAST);
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      n_q         <= '0;
      base_q      <= '0;
      r_q         <= '0;
      y_q         <= '0;
      xa_q        <= '0;
      sh_q        <= '0;
      clr_x_q     <= '0;
      collision_q <= 1'b0;
`ifdef CHIP8_SPRITE_WRAP_EN
      ovf_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      base_q      <= base_d;
      r_q         <= r_d;
      y_q         <= y_d;
      xa_q        <= xa_d;
      sh_q        <= sh_d;
      clr_x_q     <= clr_x_d;
      collision_q <= collision_d;
`ifdef CHIP8_SPRITE_WRAP_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  // Next-state logic and bus outputs.
  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    base_d         = base_q;
    r_d            = r_q;
    y_d            = y_q;
    xa_d           = xa_q;
    sh_d           = sh_q;
    clr_x_d        = clr_x_q;
    collision_d    = collision_q;
`ifdef CHIP8_SPRITE_WRAP_EN
    ovf_d          = ovf_q;
`endif
    row_done       = 1'b0;
    bus.mem_addr   = '0;
    bus.fbvx_read  = '0;
    bus.fbvy_read  = '0;
    bus.fbvx_write = '0;
    bus.fbvy_write = '0;
    bus.fbdata     = '0;
    bus.fb_write   = 1'b0;
    bus.done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          n_d         = bus.n;
          base_d      = bus.i_addr;
          r_d         = '0;
          clr_x_d     = '0;
          collision_d = 1'b0;
          if (bus.op) begin
            y_d     = '0;
            state_d = CLEAR;
          end else begin
            y_d = y0;
            // Near the right edge, read the last full byte and shift the
            // sprite into it; the overflow goes to the high ext byte.
            if (x0 > XLAST) begin
              xa_d = XLAST;
              sh_d = 3'(x0 - XLAST);
            end else begin
              xa_d = x0;
              sh_d = '0;
            end
            state_d = (bus.n == 4'd0) ? DONE : FETCH;
          end
        end
      end
      CLEAR: begin
        bus.fb_write   = 1'b1;
        bus.fbvx_write = clr_x_q;
        bus.fbvy_write = y_q;
        if (clr_x_q == XLAST) begin
          clr_x_d = '0;
          if (y_q == YLAST) state_d = DONE;
          else              y_d     = y_q + 8'd1;
        end else begin
          clr_x_d = clr_x_q + 8'd8;
        end
      end
      FETCH: begin
        bus.mem_addr  = base_q + ADDR_W'(r_q);
        bus.fbvx_read = xa_q;
        bus.fbvy_read = y_q;
        state_d       = MERGE;
      end
      MERGE: begin
        bus.fb_write   = 1'b1;
        bus.fbvx_write = xa_q;
        bus.fbvy_write = y_q;
        bus.fbdata     = bus.fb_readdata ^ ext_lo;
        collision_d    = collision_q | (|(bus.fb_readdata & ext_lo));
`ifdef CHIP8_SPRITE_WRAP_EN
        ovf_d = ext_hi;
        if (ext_hi != 8'h00) state_d  = WRAP_RD;
        else                 row_done = 1'b1;
`else
        row_done = 1'b1;
`endif
      end
`ifdef CHIP8_SPRITE_WRAP_EN
      WRAP_RD: begin
        bus.fbvy_read = y_q;
        state_d       = WRAP_WR;
      end
      WRAP_WR: begin
        bus.fb_write   = 1'b1;
        bus.fbvy_write = y_q;
        bus.fbdata     = bus.fb_readdata ^ ovf_q;
        collision_d    = collision_q | (|(bus.fb_readdata & ovf_q));
        row_done       = 1'b1;
      end
`endif
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Row finished: either stop or move to the next sprite row.
    if (row_done) begin
      if (row_last) begin
        state_d = DONE;
      end else begin
        r_d     = r_q + 4'd1;
        y_d     = y_step;
        state_d = FETCH;
      end
    end
  end

  assign bus.busy      = (state_q != IDLE) && (state_q != DONE);
  assign bus.collision = collision_q;
endmodule

// File: tb/tb_chip8_sprite_draw_ctrl.sv
// Randomized self-checking bench for chip8_sprite_draw_ctrl against a
// pixel-level reference model of the CHIP-8 draw/clear semantics.
module tb_chip8_sprite_draw_ctrl;
  localparam int FB_W   = 64;
  localparam int FB_H   = 32;
  localparam int ADDR_W = 12;
`ifdef CHIP8_SPRITE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  chip8_sprite_draw_ctrl_if #(.ADDR_W(ADDR_W)) bus();

  chip8_sprite_draw_ctrl #(.FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- environment: sprite memory and framebuffer -------------
  logic [7:0]      mem [1<<ADDR_W];
  bit   [FB_W-1:0] fb_mem [FB_H];
  int              wr_cnt = 0;
  int              bad_wr = 0;
  int              wr_x [512];
  int              wr_y [512];

  always @(posedge clk) bus.mem_readdata <= mem[bus.mem_addr];

  always @(posedge clk) begin
    int rx, ry, wx, wy;
    rx = int'(bus.fbvx_read);
    ry = int'(bus.fbvy_read);
    if (ry < FB_H && rx <= FB_W - 8) bus.fb_readdata <= fb_mem[ry][rx +: 8];
    else                             bus.fb_readdata <= 8'h00;
    if (bus.fb_write) begin
      wx = int'(bus.fbvx_write);
      wy = int'(bus.fbvy_write);
      if (wy < FB_H && wx <= FB_W - 8) fb_mem[wy][wx +: 8] <= bus.fbdata;
      else                             bad_wr <= bad_wr + 1;
      wr_x[wr_cnt % 512] <= wx;
      wr_y[wr_cnt % 512] <= wy;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // ---------------- reference model ----------------------------------------
  bit [FB_W-1:0] ref_fb [FB_H];
  bit            ref_col;
  int            exp_cyc;
  int            exp_wy[$];

  task automatic model_clear();
    for (int y = 0; y < FB_H; y++) ref_fb[y] = '0;
    ref_col = 1'b0;
    exp_cyc = 1 + (FB_W / 8) * FB_H;
    exp_wy.delete();
  endtask

  task automatic model_draw(input int vx, input int vy, input int n, input int addr);
    int x0, y0, x, y;
    bit over;
    logic [7:0] b;
    x0 = vx % FB_W;
    y0 = vy % FB_H;
    ref_col = 1'b0;
    exp_cyc = 1;
    exp_wy.delete();
    for (int r = 0; r < n; r++) begin
      y = y0 + r;
      if (y >= FB_H) begin
        if (!WRAP) continue;
        y -= FB_H;
      end
      b = mem[(addr + r) % (1 << ADDR_W)];
      over = 1'b0;
      for (int c = 0; c < 8; c++) begin
        if (b[7-c]) begin
          x = x0 + c;
          if (x >= FB_W) begin
            if (!WRAP) continue;
            x -= FB_W;
            over = 1'b1;
          end
          if (ref_fb[y][x]) ref_col = 1'b1;
          ref_fb[y][x] = ~ref_fb[y][x];
        end
      end
      exp_wy.push_back(y);
      exp_cyc += 2;
      if (over) begin
        exp_wy.push_back(y);
        exp_cyc += 2;
      end
    end
  endtask

  // ---------------- one operation, fully checked ----------------------------
  task automatic run_op(input string tag, input bit op, input int vx, input int vy,
                        input int n, input int addr, input bit poke);
    int w0, cyc, nwr, mism;
    if (op) model_clear();
    else    model_draw(vx, vy, n, addr);
    w0 = wr_cnt;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.vx     = 8'(vx);
    bus.vy     = 8'(vy);
    bus.n      = 4'(n);
    bus.i_addr = ADDR_W'(addr);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    if (exp_cyc > 1) check({tag, "_busy"}, int'(bus.busy), 1);
    if (poke && exp_cyc >= 3) begin
      // A second request while busy must not disturb the current one.
      bus.start = 1'b1;
      bus.op    = ~op;
      bus.vx    = bus.vx + 8'd3;
      bus.n     = 4'd9;
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
    end
    while (!bus.done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    nwr = wr_cnt - w0;
    check({tag, "_done_cycle"}, cyc, exp_cyc);
    check({tag, "_busy_at_done"}, int'(bus.busy), 0);
    check({tag, "_collision"}, int'(bus.collision), int'(ref_col));
    if (op) check({tag, "_writes"}, nwr, (FB_W / 8) * FB_H);
    else    check({tag, "_writes"}, nwr, exp_wy.size());
    if (!op)
      for (int k = 0; k < exp_wy.size() && k < nwr; k++)
        check({tag, "_wr_y"}, wr_y[(w0 + k) % 512], exp_wy[k]);
    @(negedge clk);
    check({tag, "_done_pulse"}, int'(bus.done), 0);
    check({tag, "_collision_hold"}, int'(bus.collision), int'(ref_col));
    mism = 0;
    for (int y = 0; y < FB_H; y++) if (fb_mem[y] != ref_fb[y]) mism++;
    check({tag, "_fb_rows_bad"}, mism, 0);
    $display("op %s op=%0d vx=%0d vy=%0d n=%0d addr=%0h cycles=%0d writes=%0d col=%0d",
             tag, op, vx, vy, n, addr, cyc, nwr, bus.collision);
  endtask

  // ---------------- main sequence -------------------------------------------
  initial begin
    int w0, vx, vy, n, addr;
    bus.start  = 1'b0;
    bus.op     = 1'b0;
    bus.vx     = '0;
    bus.vy     = '0;
    bus.n      = '0;
    bus.i_addr = '0;
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 8'($urandom);
    for (int y = 0; y < FB_H; y++) ref_fb[y] = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_collision", int'(bus.collision), 0);
    check("rst_fb_write", int'(bus.fb_write), 0);
    check("rst_mem_addr", int'(bus.mem_addr), 0);
    check("rst_fbvx_write", int'(bus.fbvx_write), 0);
    check("rst_fbvy_read", int'(bus.fbvy_read), 0);
    reset_n = 1'b1;

    // Messy screen first, then the clear must wipe it.
    run_op("pre_draw", 1'b0, 5, 7, 15, 12'h400, 1'b0);
    run_op("clear", 1'b1, 0, 0, 0, 0, 1'b0);

    mem[12'h200] = 8'hF0;
    run_op("draw", 1'b0, 8, 0, 1, 12'h200, 1'b0);
    check("draw_byte", int'(fb_mem[0][8 +: 8]), 8'h0F);
    run_op("redraw", 1'b0, 8, 0, 1, 12'h200, 1'b0);
    check("redraw_byte", int'(fb_mem[0][8 +: 8]), 8'h00);

    mem[12'h300] = 8'hFF;
    w0 = wr_cnt;
    run_op("edge", 1'b0, 60, 0, 1, 12'h300, 1'b0);
    check("edge_x", wr_x[w0 % 512], 56);
    check("edge_byte", int'(fb_mem[0][56 +: 8]), 8'hF0);
    if (WRAP) check("edge_wrap_byte", int'(fb_mem[0][0 +: 8]), 8'h0F);
    run_op("clear2", 1'b1, 0, 0, 0, 0, 1'b0);

    for (int k = 0; k < 4; k++) mem[12'h310 + k] = 8'h81;
    run_op("bottom", 1'b0, 16, 30, 4, 12'h310, 1'b0);

    run_op("n_zero", 1'b0, 20, 10, 0, 12'h100, 1'b0);
    run_op("busy_poke", 1'b0, 30, 12, 6, 12'h500, 1'b1);
    run_op("addr_wrap", 1'b0, 3, 20, 9, 12'hFFC, 1'b0);

    for (int t = 0; t < 40; t++) begin
      vx   = int'($urandom_range(0, 255));
      vy   = int'($urandom_range(0, 255));
      n    = int'($urandom_range(0, 15));
      addr = int'($urandom_range(0, (1 << ADDR_W) - 1));
      run_op("rand", 1'b0, vx, vy, n, addr, 1'($urandom));
    end

    // Asynchronous reset in the middle of a draw.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = 1'b0;
    bus.vx     = 8'd4;
    bus.vy     = 8'd2;
    bus.n      = 4'd15;
    bus.i_addr = 12'h600;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_fb_write", int'(bus.fb_write), 0);
    check("midrst_done", int'(bus.done), 0);
    $display("op midrst reset asserted during draw busy=%0d fb_write=%0d", bus.busy, bus.fb_write);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("clear3", 1'b1, 0, 0, 0, 0, 1'b0);

    check("bad_writes", bad_wr, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
